tdm_demux_4ch: RTL and testbench

- Receive-side counterpart of the team's 4:1 select-line mux.
- Takes a time-division-multiplexed word stream (one word per valid beat, slots 0..3 in order, slot 0 flagged by `sync`).
- Distributes the words into four channel registers and publishes all four simultaneously once per complete frame.
- Sits at the far end of a serial/TDM link, feeding per-channel consumers.

---
 rtl/tdm_demux_4ch.sv | 139 +++++++++++++
 tb/tb_tdm_demux_4ch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive-side TDM demultiplexer, 4 slots per frame.
//
// Each cycle with dvalid=1 carries one word. sync flags slot 0. Words for
// slots 0..2 are held in shadow registers. The slot-3 word goes directly to
// z3, and all four channel outputs update together. After lock, a missing
// sync at slot 0 is tolerated (flywheel). A sync that arrives mid-frame
// drops the partial frame, raises sync_err and restarts the frame at slot 0.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   din, dvalid    TDM word and its valid strobe
//   sync           slot-0 marker, only looked at when dvalid=1
//   z0..z3         channel words of the last published frame
//   frame_valid    one-cycle pulse when z0..z3 update
//   locked         high once the first sync has been accepted
//   sync_err       one-cycle pulse when a sync lands mid-frame
//
// Optional build macro TDM_DEMUX_PARITY_EN adds:
//   dpar           even parity over din, sampled with each beat
//   par_err        one-cycle pulse in place of frame_valid for a frame
//                  that had a parity error; z0..z3 keep their old values
//
// State  | meaning
// HUNT   | waiting for a sync beat; non-sync beats are dropped
// LOCKED | tracking slots 0..3; leaves this state only on reset
module tdm_demux_4ch #(
  parameter int WIDTH = 8,
  parameter int Tpd   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             dvalid,
  input  logic             sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic             dpar,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] z0,
  output logic [WIDTH-1:0] z1,
  output logic [WIDTH-1:0] z2,
  output logic [WIDTH-1:0] z3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  // Tpd only applies to behavioural models. The synthesized outputs have
  // no delay. Negative values are meaningless, so this block does nothing.
  if (Tpd < 0) begin : g_tpd_unused
  end

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic             take0;
  logic             complete;
  logic             publish_ok;

  // A beat starts a new frame when it acquires lock, when it falls on slot 0,
  // or when sync arrives early. An early sync takes priority over completion.
  assign take0    = dvalid && (sync || (state == LOCKED && slot == 2'd0));
  assign complete = dvalid && !sync && state == LOCKED && slot == 2'd3;

`ifdef TDM_DEMUX_PARITY_EN
  logic beat_bad;
  logic frame_bad;

  assign beat_bad   = ^{din, dpar};
  assign publish_ok = !(frame_bad || beat_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_bad <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      par_err <= complete && !publish_ok;
      if (take0)
        frame_bad <= beat_bad;
      else if (dvalid && state == LOCKED)
        frame_bad <= frame_bad || beat_bad;
    end
  end
`else
  assign publish_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      z0          <= '0;
      z1          <= '0;
      z2          <= '0;
      z3          <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (take0) begin
        sh0      <= din;
        slot     <= 2'd1;
        state    <= LOCKED;
        locked   <= 1'b1;
        sync_err <= (state == LOCKED) && (slot != 2'd0);
      end else if (dvalid && state == LOCKED) begin
        case (slot)
          2'd1: begin
            sh1  <= din;
            slot <= 2'd2;
          end
          2'd2: begin
            sh2  <= din;
            slot <= 2'd3;
          end
          2'd3: begin
            slot <= 2'd0;
            if (publish_ok) begin
              z0          <= sh0;
              z1          <= sh1;
              z2          <= sh2;
              z3          <= din;
              frame_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: scoreboard bench for tdm_demux_4ch.
// A reference model runs on each driven beat and queues the pulse expected
// on the outputs (frame_valid / sync_err / par_err), together with its cycle
// and the frame contents. A negedge monitor pops each observed pulse and
// compares it with the queued entry. Every cycle it also compares z0..z3 and
// locked against the model.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       dvalid;
  logic       sync;
  logic [7:0] z0, z1, z2, z3;
  logic       frame_valid, locked, sync_err;
  logic       par_err_w;
`ifdef TDM_DEMUX_PARITY_EN
  logic       dpar;
`endif

  tdm_demux_4ch #(.WIDTH(8), .Tpd(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .dvalid      (dvalid),
    .sync        (sync),
`ifdef TDM_DEMUX_PARITY_EN
    .dpar        (dpar),
    .par_err     (par_err_w),
`endif
    .z0          (z0),
    .z1          (z1),
    .z2          (z2),
    .z3          (z3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

`ifndef TDM_DEMUX_PARITY_EN
  assign par_err_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // kind: 0 = frame_valid, 1 = sync_err, 2 = par_err
  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] z;
  } ev_t;
  ev_t sb[$];

  logic        m_locked = 1'b0;
  logic [1:0]  m_slot   = 2'd0;
  logic [7:0]  m_sh[3];
  logic        m_bad    = 1'b0;
  logic [31:0] mz       = 32'h0;

  task automatic push_ev(input int k, input int c, input logic [31:0] zz);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.z    = zz;
    sb.push_back(e);
  endtask

  task automatic model_beat(input logic [7:0] d, input logic s, input logic pok, input int c);
    if (!m_locked) begin
      if (s) begin
        m_sh[0] = d; m_slot = 2'd1; m_locked = 1'b1; m_bad = !pok;
      end
    end else if (s && m_slot != 2'd0) begin
      push_ev(1, c + 1, 32'h0);
      m_sh[0] = d; m_slot = 2'd1; m_bad = !pok;
    end else begin
      case (m_slot)
        2'd0: begin m_sh[0] = d; m_slot = 2'd1; m_bad = !pok; end
        2'd1: begin m_sh[1] = d; m_slot = 2'd2; m_bad = m_bad | !pok; end
        2'd2: begin m_sh[2] = d; m_slot = 2'd3; m_bad = m_bad | !pok; end
        default: begin
          if (m_bad || !pok) push_ev(2, c + 1, 32'h0);
          else push_ev(0, c + 1, {d, m_sh[2], m_sh[1], m_sh[0]});
          m_slot = 2'd0;
        end
      endcase
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_slot = 2'd0; m_bad = 1'b0; mz = 32'h0;
    sb.delete();
  endtask

  // Inputs change 1 time unit after the negedge. The monitor at the negedge
  // therefore always sees the model state left by the previous cycle.
  task automatic beat(input logic [7:0] d, input logic s, input logic pok = 1'b1);
    @(negedge clk); #1;
    din = d; dvalid = 1'b1; sync = s;
`ifdef TDM_DEMUX_PARITY_EN
    dpar = (^d) ^ !pok;
`endif
    model_beat(d, s, pok, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      dvalid = 1'b0;
      sync   = 1'($urandom_range(0, 1));
      din    = 8'($urandom);
    end
  endtask

  task automatic async_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; dvalid = 1'b0; sync = 1'b0;
    model_reset();
    #1;
    check("arst_z", {z3, z2, z1, z0}, 32'h0);
    check("arst_flags", {29'h0, frame_valid, sync_err, locked}, 32'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      int  nev;
      int  kobs;
      ev_t e;
      nev  = int'(frame_valid) + int'(sync_err) + int'(par_err_w);
      kobs = (nev > 1) ? 7 : frame_valid ? 0 : sync_err ? 1 : 2;
      if (nev > 0) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'(kobs), 32'hFFFF);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", 32'(kobs), 32'(e.kind));
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
          if (e.kind == 0) mz = e.z;
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        check("missed_pulse", 32'(cyc), 32'(e.cyc));
      end
      check("z", {z3, z2, z1, z0}, mz);
      check("locked", {31'h0, locked}, {31'h0, m_locked});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; din = 8'h0; dvalid = 1'b0; sync = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    dpar = 1'b0;
`endif
    #7;
    check("rst_z", {z3, z2, z1, z0}, 32'h0);
    check("rst_flags", {29'h0, frame_valid, sync_err, locked}, 32'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Back-to-back frame from reset.
    beat(8'h11, 1'b1); beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
    idle(3);
    check("t1_z", {z3, z2, z1, z0}, 32'h44332211);

    // In HUNT, beats without sync are dropped.
    async_reset();
    idle(1);
    beat(8'hAA, 1'b0); beat(8'hBB, 1'b0);
    idle(1);
    check("t2_hunt", {31'h0, locked}, 32'h0);
    beat(8'h01, 1'b1); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
    idle(2);
    check("t2_z", {z3, z2, z1, z0}, 32'h04030201);

    // Sparse beats, then a frame with no sync (flywheel).
    for (int i = 0; i < 8; i++) begin
      beat(8'(5 + i), (i == 0));
      idle(2);
    end
    idle(2);
    check("t3_z", {z3, z2, z1, z0}, 32'h0C0B0A09);

    // Mid-frame sync: the partial frame is dropped.
    beat(8'h10, 1'b1); beat(8'h20, 1'b0);
    beat(8'h30, 1'b1); beat(8'h40, 1'b0); beat(8'h50, 1'b0); beat(8'h60, 1'b0);
    idle(2);
    check("t4_z", {z3, z2, z1, z0}, 32'h60504030);

    // Sync landing on slot 3 counts as an error, not a completion.
    beat(8'h71, 1'b0); beat(8'h72, 1'b0); beat(8'h73, 1'b0); beat(8'h74, 1'b1);
    beat(8'h75, 1'b0); beat(8'h76, 1'b0); beat(8'h77, 1'b0);
    idle(2);
    check("t4b_z", {z3, z2, z1, z0}, 32'h77767574);

    // Async reset in the middle of a frame.
    beat(8'hD1, 1'b1); beat(8'hD2, 1'b0);
    async_reset();
    beat(8'h77, 1'b0);
    idle(3);
    check("t5_hunt", {31'h0, locked}, 32'h0);
    beat(8'hE1, 1'b1); beat(8'hE2, 1'b0); beat(8'hE3, 1'b0); beat(8'hE4, 1'b0);
    idle(2);
    check("t5_z", {z3, z2, z1, z0}, 32'hE4E3E2E1);

`ifdef TDM_DEMUX_PARITY_EN
    // A parity error on one beat suppresses that frame only.
    beat(8'h01, 1'b1); beat(8'h02, 1'b0); beat(8'h03, 1'b0, 1'b0); beat(8'h04, 1'b0);
    idle(2);
    check("t6_hold", {z3, z2, z1, z0}, 32'hE4E3E2E1);
    beat(8'h15, 1'b1); beat(8'h16, 1'b0); beat(8'h17, 1'b0); beat(8'h18, 1'b0);
    idle(2);
    check("t6_z", {z3, z2, z1, z0}, 32'h18171615);
`endif

    idle(4);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
